// File: rtl/secuenciador_memoria_pkg.sv
// Shared types and default sizes for the waveform playback sequencer.
package secuenciador_memoria_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } estado_t;

  localparam int M_DEF     = 12;
  localparam int AW_DEF    = 10;
  localparam int DEPTH_DEF = 150;
  localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/secuenciador_memoria_generador_tick.sv
// Loadable pacing divider: latches div on load and ticks once every div+1 enabled cycles.
module generador_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cnt;

  // Loading the counter with div itself makes the first enabled cycle a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_lat <= '0;
      div_cnt <= '0;
    end else if (load) begin
      div_lat <= div;
      div_cnt <= div;
    end else if (enable) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = enable && (div_cnt == div_lat);

endmodule

// File: rtl/secuenciador_memoria.sv
// Per-channel ROM playback controller: paced address generation, 2-cycle read pipeline,
// one-shot or wrapping playback with busy/done status.
module secuenciador_memoria
  import secuenciador_memoria_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_cont,
  input  logic [DIV_W-1:0] div,
  output logic [AW-1:0]    dir,
  input  logic [M-1:0]     mem_data,
  output logic [M-1:0]     sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  estado_t       state;
  estado_t       state_next;
  logic [AW-1:0] dir_next;
  logic          mode_lat;
  logic          p1;
  logic          load;
  logic          issue;
  logic          tick;

  generador_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .enable(state == RUN),
    .div   (div),
    .tick  (tick)
  );

  // stop outranks a same-cycle tick, so no new read is issued on the way out.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    load       = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = RUN;
          dir_next   = '0;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = DRAIN;
        end else if (tick) begin
          issue = 1'b1;
          if (dir != LAST) begin
            dir_next = dir + AW'(1);
          end else if (mode_lat) begin
            dir_next = '0;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!p1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dir          <= '0;
      mode_lat     <= 1'b0;
      p1           <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      dir          <= dir_next;
      p1           <= issue;
      sample_valid <= p1;
      if (load) mode_lat <= mode_cont;
      if (p1)   sample   <= mem_data;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DRAIN) && !p1;

endmodule

// File: tb/tb_secuenciador_memoria.sv
// Self-checking bench: random ROM contents and live input noise, checked against a
// cycle-schedule model of when each read, sample and done must appear.
module tb_secuenciador_memoria;

  localparam int M     = 12;
  localparam int AW    = 10;
  localparam int DEPTH = 150;
  localparam int DIV_W = 8;
  localparam int HORIZON = 2000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode_cont = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [AW-1:0]    dir;
  logic [M-1:0]     mem_data = '0;
  logic [M-1:0]     sample;
  logic             sample_valid;
  logic             busy;
  logic             done;

  logic [M-1:0] rom [0:DEPTH-1];
  int vectors = 0;
  int miscompares = 0;

  // expected schedule (cycle index 0 = first cycle after start is taken)
  int           exp_vj[$];
  logic [M-1:0] exp_vs[$];
  int           exp_dir[$];
  int           exp_done;
  // observed
  int           obs_vj[$];
  logic [M-1:0] obs_vs[$];
  int           obs_done[$];
  logic [AW-1:0] obs_dir[$];
  logic         obs_busy[$];

  secuenciador_memoria dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode_cont   (mode_cont),
    .div         (div),
    .dir         (dir),
    .mem_data    (mem_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[dir];

  // Reads happen every d+1 cycles from cycle 0, each read k returns ROM[k mod DEPTH]
  // two cycles later; playback ends after DEPTH reads (one-shot) or at stop.
  task automatic build_model(input int d, input bit mode, input int stop_j);
    int  reads = 0;
    bit  ended = 0;
    exp_vj.delete(); exp_vs.delete(); exp_dir.delete();
    exp_done = -1;
    for (int j = 0; j < HORIZON; j++) begin
      exp_dir.push_back(mode ? reads % DEPTH : (reads < DEPTH - 1 ? reads : DEPTH - 1));
      if (!ended && stop_j >= 0 && j == stop_j) begin
        ended = 1;
        exp_done = j + 1;
      end else if (!ended && j % (d + 1) == 0) begin
        exp_vj.push_back(j + 2);
        exp_vs.push_back(rom[reads % DEPTH]);
        reads++;
        if (!mode && reads == DEPTH) begin
          ended = 1;
          exp_done = j + 2;
        end
      end
    end
  endtask

  // Starts playback at the current negedge and records n cycles of outputs,
  // scrambling div/mode/start while they must be ignored.
  task automatic run_case(input int d, input bit mode, input int stop_j, input int n);
    obs_vj.delete(); obs_vs.delete(); obs_done.delete(); obs_dir.delete(); obs_busy.delete();
    div = DIV_W'(d); mode_cont = mode; stop = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      obs_dir.push_back(dir);
      obs_busy.push_back(busy);
      if (sample_valid) begin
        obs_vj.push_back(j);
        obs_vs.push_back(sample);
      end
      if (done) obs_done.push_back(j);
      div       = DIV_W'($urandom);
      mode_cont = 1'($urandom_range(0, 1));
      start     = (j < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop      = (stop_j >= 0 && j >= stop_j && j <= exp_done);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (dir !== '0 || sample !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got dir=%0d sample=%0d valid=%b busy=%b done=%b, expected all 0",
               dir, sample, sample_valid, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (dir !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got dir=%0d valid=%b busy=%b done=%b, expected all 0",
               dir, sample_valid, busy, done);
    end
    $display("reset: outputs cleared, idle after release");
  endtask

  task automatic test_oneshot();
    int divs [2] = '{0, 3};
    int nv;
    for (int c = 0; c < 2; c++) begin
      build_model(divs[c], 1'b0, -1);
      run_case(divs[c], 1'b0, -1, exp_done + 3);
      $display("oneshot div=%0d: %0d samples, done count %0d", divs[c], obs_vj.size(), obs_done.size());
      vectors++;
      if (obs_vj.size() != exp_vj.size()) begin
        miscompares++;
        $display("FAIL oneshot_count div=%0d: got %0d, expected %0d", divs[c], obs_vj.size(), exp_vj.size());
      end
      nv = (obs_vj.size() < exp_vj.size()) ? obs_vj.size() : exp_vj.size();
      for (int k = 0; k < nv; k++) begin
        vectors++;
        if (obs_vj[k] != exp_vj[k] || obs_vs[k] !== exp_vs[k]) begin
          miscompares++;
          $display("FAIL oneshot_sample div=%0d k=%0d: got %0d at %0d, expected %0d at %0d",
                   divs[c], k, obs_vs[k], obs_vj[k], exp_vs[k], exp_vj[k]);
        end
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] != exp_done) begin
        miscompares++;
        $display("FAIL oneshot_done div=%0d: got %0d pulses first at %0d, expected 1 at %0d", divs[c],
                 obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
      end
      for (int j = 0; j < obs_dir.size(); j++) begin
        vectors++;
        if (obs_dir[j] !== AW'(exp_dir[j]) || obs_busy[j] !== (j <= exp_done)) begin
          miscompares++;
          $display("FAIL oneshot_dir_busy div=%0d cycle %0d: got dir=%0d busy=%b, expected dir=%0d busy=%b",
                   divs[c], j, obs_dir[j], obs_busy[j], exp_dir[j], (j <= exp_done));
        end
      end
    end
  endtask

  task automatic test_stop();
    int ds [3];
    bit ms [3];
    int ss [3];
    int nv;
    ds = '{0, 0, 3};
    ms = '{1'b1, 1'b0, 1'b1};
    ss = '{400, 10, 4 * $urandom_range(50, 100) + 2};
    for (int c = 0; c < 3; c++) begin
      build_model(ds[c], ms[c], ss[c]);
      run_case(ds[c], ms[c], ss[c], exp_done + 3);
      $display("stop div=%0d mode=%0d at %0d: %0d samples, done count %0d",
               ds[c], ms[c], ss[c], obs_vj.size(), obs_done.size());
      vectors++;
      if (obs_vj.size() != exp_vj.size()) begin
        miscompares++;
        $display("FAIL stop_count case %0d: got %0d, expected %0d", c, obs_vj.size(), exp_vj.size());
      end
      nv = (obs_vj.size() < exp_vj.size()) ? obs_vj.size() : exp_vj.size();
      for (int k = 0; k < nv; k++) begin
        vectors++;
        if (obs_vj[k] != exp_vj[k] || obs_vs[k] !== exp_vs[k]) begin
          miscompares++;
          $display("FAIL stop_sample case %0d k=%0d: got %0d at %0d, expected %0d at %0d",
                   c, k, obs_vs[k], obs_vj[k], exp_vs[k], exp_vj[k]);
        end
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] != exp_done) begin
        miscompares++;
        $display("FAIL stop_done case %0d: got %0d pulses first at %0d, expected 1 at %0d", c,
                 obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
      end
      for (int j = 0; j < obs_dir.size(); j++) begin
        vectors++;
        if (obs_dir[j] !== AW'(exp_dir[j]) || obs_busy[j] !== (j <= exp_done)) begin
          miscompares++;
          $display("FAIL stop_dir_busy case %0d cycle %0d: got dir=%0d busy=%b, expected dir=%0d busy=%b",
                   c, j, obs_dir[j], obs_busy[j], exp_dir[j], (j <= exp_done));
        end
      end
    end
  endtask

  // Second start lands in the cycle right after done.
  task automatic test_back_to_back();
    int ds [2];
    int nv;
    ds = '{$urandom_range(1, 5), 0};
    for (int c = 0; c < 2; c++) begin
      build_model(ds[c], 1'b0, -1);
      run_case(ds[c], 1'b0, -1, exp_done + ((c == 0) ? 1 : 3));
      $display("back_to_back run %0d div=%0d: %0d samples", c, ds[c], obs_vj.size());
      vectors++;
      if (obs_vj.size() != exp_vj.size()) begin
        miscompares++;
        $display("FAIL b2b_count run %0d: got %0d, expected %0d", c, obs_vj.size(), exp_vj.size());
      end
      nv = (obs_vj.size() < exp_vj.size()) ? obs_vj.size() : exp_vj.size();
      for (int k = 0; k < nv; k++) begin
        vectors++;
        if (obs_vj[k] != exp_vj[k] || obs_vs[k] !== exp_vs[k]) begin
          miscompares++;
          $display("FAIL b2b_sample run %0d k=%0d: got %0d at %0d, expected %0d at %0d",
                   c, k, obs_vs[k], obs_vj[k], exp_vs[k], exp_vj[k]);
        end
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] != exp_done) begin
        miscompares++;
        $display("FAIL b2b_done run %0d: got %0d pulses first at %0d, expected 1 at %0d", c,
                 obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
      end
      for (int j = 0; j < obs_dir.size(); j++) begin
        vectors++;
        if (obs_dir[j] !== AW'(exp_dir[j]) || obs_busy[j] !== (j <= exp_done)) begin
          miscompares++;
          $display("FAIL b2b_dir_busy run %0d cycle %0d: got dir=%0d busy=%b, expected dir=%0d busy=%b",
                   c, j, obs_dir[j], obs_busy[j], exp_dir[j], (j <= exp_done));
        end
      end
    end
  endtask

  task automatic test_async_abort();
    div = '0; mode_cont = 1'b0; stop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (75) @(negedge clk);
    vectors++;
    if (dir !== AW'(75) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got dir=%0d busy=%b, expected dir=75 busy=1", dir, busy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (dir !== '0 || sample !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_clear: got dir=%0d sample=%0d valid=%b busy=%b done=%b, expected all 0",
               dir, sample, sample_valid, busy, done);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || sample_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet cycle %0d: got done=%b valid=%b, expected 0 0", j, done, sample_valid);
      end
    end
    reset = 1'b1;
    start = 1'b1; stop = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || dir !== '0 || sample_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL start_stop_idle cycle %0d: got busy=%b dir=%0d valid=%b, expected 0 0 0",
                 j, busy, dir, sample_valid);
      end
    end
    stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (dir !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_entry: got dir=%0d busy=%b, expected dir=0 busy=1", dir, busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (sample_valid !== 1'b1 || sample !== rom[0]) begin
      miscompares++;
      $display("FAIL restart_first: got valid=%b sample=%0d, expected valid=1 sample=%0d",
               sample_valid, sample, rom[0]);
    end
    stop = 1'b1;
    repeat (4) @(negedge clk);
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_stop: got busy=%b, expected 0", busy);
    end
    $display("async abort: cleared at dir 75, restart from 0");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = M'(i);
    test_reset();
    test_oneshot();
    for (int i = 0; i < DEPTH; i++) rom[i] = M'($urandom);
    test_stop();
    test_back_to_back();
    test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secuenciador_memoria.md
Name: secuenciador_memoria

Overview:
- Playback controller for one per-channel waveform ROM: 150 words × 12 bits, registered read, 1-cycle latency.
- Drives the ROM address (dir) and captures the returned word.
- Emits a paced sample stream with valid/busy/done status, in one-shot or continuous (wrap) mode.
- Sits between the top-level control (buttons/switches on the Nexys top) and each channel ROM; one instance per channel.

Parameters:
- M, 12, data word width (matches ROM word).
- AW, 10, ROM address width.
- DEPTH, 150, number of valid ROM words; last address is DEPTH-1.
- DIV_W, 8, width of the pacing divider.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begin playback when idle.
- stop  in  1  level; abort playback after in-flight read drains.
- mode_cont  in  1  1 = wrap DEPTH-1→0 forever, 0 = one pass; latched at start.
- div  in  DIV_W  pacing: one read every div+1 clocks; latched at start.
- dir  out  AW  ROM address (registered).
- mem_data  in  M  ROM data_out.
- sample  out  M  captured ROM word (registered).
- sample_valid  out  1  one-cycle pulse per sample.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset (reset=0, async) clears all outputs and state:
  - dir=0, sample=0, sample_valid=0, busy=0, done=0.
  - state=IDLE, pending flag p1=0, div_cnt=0, latched div/mode=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and stop=0 → RUN; dir=0, latch div and mode_cont, div_cnt=div_latched (so the first tick occurs in the first RUN cycle).
  - start=1 and stop=1 together → stay IDLE.
- Tick: asserted in RUN when div_cnt==div_latched; div_cnt resets to 0 on tick, otherwise increments. div=0 gives a tick every cycle.
- Read pipeline, tick in cycle t with dir=A:
  - The ROM samples A at the end of t.
  - p1=1 in t+1; sample is loaded from mem_data at the end of t+1.
  - sample=ROM[A] and sample_valid=1 in t+2. Fixed latency of 2 cycles from tick to valid.
- Address advance at the tick edge:
  - A<DEPTH-1 → dir=A+1.
  - A==DEPTH-1 with mode latched=1 → dir=0, stay RUN.
  - A==DEPTH-1 with mode latched=0 → dir holds, go to DRAIN.
  - dir never exceeds DEPTH-1.
- stop in RUN: has priority over a same-cycle tick (no read issued that cycle) → DRAIN. The in-flight read, if any, still produces its sample.
- start in RUN or DRAIN is ignored. Live changes to div/mode_cont during RUN are ignored.
- DRAIN:
  - Stay while p1=1.
  - When p1=0: done=1 for exactly that cycle, → IDLE. done coincides with the final sample_valid when the last read is in flight; stop with nothing in flight gives done one cycle after stop, with no sample.
- done is decoded from registers as (state==DRAIN && !p1). sample_valid is registered. busy is decoded from state.
- sample holds its last value between valid pulses.
- Async reset mid-operation aborts immediately: no done pulse, no sample_valid.
- After done, a new start is accepted in the following cycle.

Decomposition:
- Shared package: state encodings (IDLE/RUN/DRAIN), default M=12, AW=10, DEPTH=150.
- One sub-module, generador_tick: loadable divider (load, enable, div in; tick out). The rest of the logic stays in the top of this block.

Test Plan:
- Reset then release; ROM loaded with ROM[i]=i → all outputs 0, busy=0, dir=0.
- start pulse, div=0, mode_cont=0:
  - dir steps 0..149 on consecutive cycles.
  - sample_valid high for 150 consecutive cycles starting 2 cycles after entry to RUN.
  - samples 0..149 in order; done pulses once with sample 149; busy then drops.
- div=3, mode_cont=0 → sample_valid every 4th cycle, exactly 150 pulses, spacing constant at the 149 boundary.
- mode_cont=1, div=0, run 400 cycles then assert stop:
  - sequence …148, 149, 0, 1… wraps with no gap.
  - at most one extra sample after stop, then done; dir never ≥150.
- stop asserted in the tick cycle of address 10 → address 10 not read, last sample = ROM[9], done in the same cycle as ROM[9] valid.
- Assert reset low mid-run at address 75 → outputs cleared asynchronously, no done. After release, start restarts at dir=0; start+stop simultaneously in IDLE → stays IDLE.
